// File: rtl/rd_ptr_ctrl.sv
// rd_ptr_ctrl: per-stream read pointer / occupancy manager for the
// multi-stream buffer. Read requests from all ports are granted in port
// order up to each stream's occupancy; one write per cycle is accepted into
// a non-full stream, and one stream can be flushed per cycle.

module rd_ptr_ctrl_chk #(
   parameter int nstrms = 64,
   parameter int ow     = 2,
   parameter int cw     = 4,
   parameter int depth  = 2
)(
   input logic                   clk,
   input logic                   reset,
   input logic [nstrms*ow-1:0]   occ_flat,
   input logic [nstrms*cw-1:0]   acc_flat
);

   // Occupancy must stay within 0..depth; a read may never take more than is stored.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int s = 0; s < nstrms; s++) begin
            assert (int'(occ_flat[s*ow +: ow]) <= depth)
               else $error("occupancy above depth on stream %0d", s);
            assert (int'(occ_flat[s*ow +: ow]) - int'(acc_flat[s*cw +: cw]) >= 0)
               else $error("occupancy underflow on stream %0d", s);
         end
      end
   end

endmodule

module rd_ptr_ctrl #(
   parameter int nstrms    = 64,
   parameter int sid_width = $clog2(nstrms),
   parameter int nports    = 8,
   parameter int ptr_width = 1
)(
   input  logic                            clk,
   input  logic                            reset,
   input  logic [nports*nstrms-1:0]        i_req_v,
   output logic [nports*nstrms-1:0]        i_req_r,
   output logic [nstrms*ptr_width-1:0]     o_ptrs,
   input  logic                            i_wr_v,
   output logic                            i_wr_r,
   input  logic [sid_width-1:0]            i_wr_sid,
   output logic [ptr_width-1:0]            o_wr_ptr,
   input  logic                            i_flush_v,
   input  logic [sid_width-1:0]            i_flush_sid,
   output logic [nstrms*(ptr_width+1)-1:0] o_occ
);

   localparam int ow   = ptr_width + 1;
   localparam int cw   = $clog2(nports + 1);
   localparam int cmpw = (cw > ow) ? cw : ow;
   localparam logic [ow-1:0] depth = {1'b1, {ptr_width{1'b0}}};

   logic [ptr_width-1:0] rptr     [nstrms];
   logic [ptr_width-1:0] rptr_nxt [nstrms];
   logic [ow-1:0]        occ      [nstrms];
   logic [ow-1:0]        occ_nxt  [nstrms];
   logic [cw-1:0]        acc      [nstrms];
   logic [nstrms*cw-1:0] acc_flat;
   logic                 wr_fire;

   // Number of entries actually handed out: requests capped by what is stored.
   function automatic logic [cw-1:0] min_cnt(input logic [cw-1:0] cnt, input logic [ow-1:0] avail);
      if (cmpw'(cnt) <= cmpw'(avail)) begin
         min_cnt = cnt;
      end else begin
         min_cnt = cw'(avail);
      end
   endfunction

   // Prefix grant: the k-th requesting port of a stream is granted while k <= occupancy.
   always_comb begin
      logic [cw-1:0] cnt;
      i_req_r = '0;
      for (int s = 0; s < nstrms; s++) begin
         cnt = '0;
         for (int p = 0; p < nports; p++) begin
            if (i_req_v[p*nstrms+s]) begin
               cnt = cnt + cw'(1'b1);
               i_req_r[p*nstrms+s] = !reset && (cmpw'(cnt) <= cmpw'(occ[s]));
            end else begin
               i_req_r[p*nstrms+s] = 1'b0;
            end
         end
         acc[s] = min_cnt(cnt, occ[s]);
      end
   end

   // Write handshake and slot; a full stream refuses regardless of same-cycle reads.
   always_comb begin
      i_wr_r   = (occ[i_wr_sid] != depth);
      o_wr_ptr = rptr[i_wr_sid] + occ[i_wr_sid][ptr_width-1:0];
      wr_fire  = i_wr_v && i_wr_r;
   end

   // Next pointer/occupancy per stream; a flush jumps the read pointer to the write slot.
   always_comb begin
      for (int s = 0; s < nstrms; s++) begin
         if (i_flush_v && (i_flush_sid == sid_width'(s))) begin
            rptr_nxt[s] = rptr[s] + occ[s][ptr_width-1:0];
            occ_nxt[s]  = '0;
         end else begin
            rptr_nxt[s] = rptr[s] + ptr_width'(acc[s]);
            if (wr_fire && (i_wr_sid == sid_width'(s))) begin
               occ_nxt[s] = occ[s] - ow'(acc[s]) + ow'(1'b1);
            end else begin
               occ_nxt[s] = occ[s] - ow'(acc[s]);
            end
         end
      end
   end

   // Per-stream state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < nstrms; s++) begin
            rptr[s] <= '0;
            occ[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < nstrms; s++) begin
            rptr[s] <= rptr_nxt[s];
            occ[s]  <= occ_nxt[s];
         end
      end
   end

   // Flatten registered state onto the output buses.
   always_comb begin
      for (int s = 0; s < nstrms; s++) begin
         o_ptrs[s*ptr_width +: ptr_width] = rptr[s];
         o_occ[s*ow +: ow]                = occ[s];
         acc_flat[s*cw +: cw]             = acc[s];
      end
   end

   rd_ptr_ctrl_chk #(
      .nstrms (nstrms),
      .ow     (ow),
      .cw     (cw),
      .depth  (1 << ptr_width)
   ) u_chk (
      .clk      (clk),
      .reset    (reset),
      .occ_flat (o_occ),
      .acc_flat (acc_flat)
   );

endmodule

// File: doc/rd_ptr_ctrl.md
# rd_ptr_ctrl

Per-stream read-pointer and occupancy manager for the multi-stream buffer; it sits between the write path and the `nports` read ports. It accepts the transposed one-hot read requests from all read ports and grants them in port order, limited to the data available in each stream. Each cycle it advances every stream's read pointer by the number of granted requests and publishes the pointer array the read ports use to form L1 BRAM addresses. It also tracks per-stream occupancy, accepts write notifications and supplies the BRAM write pointer for the stream being written.

## Interface
Parameters:
- `nstrms`, 64, number of streams
- `sid_width`, `$clog2(nstrms)`, stream id width
- `nports`, 8, number of read ports
- `ptr_width`, 1, per-stream pointer width; stream depth D = 2^`ptr_width`

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `i_req_v`  in  `nports*nstrms`  read requests, port-major: bit p*`nstrms`+s = port p requests stream s; at most one bit set per port
- `i_req_r`  out  `nports*nstrms`  grant per request bit, same layout
- `o_ptrs`  out  `nstrms*ptr_width`  current read pointer per stream, stream s at [s*`ptr_width` +: `ptr_width`]
- `i_wr_v`  in  1  write of one entry into a stream
- `i_wr_r`  out  1  write accepted
- `i_wr_sid`  in  `sid_width`  stream being written
- `o_wr_ptr`  out  `ptr_width`  BRAM write slot for `i_wr_sid`
- `i_flush_v`  in  1  flush one stream (always accepted)
- `i_flush_sid`  in  `sid_width`  stream to flush
- `o_occ`  out  `nstrms*(ptr_width+1)`  occupancy per stream, 0..D

## Operation
- **State.** Per stream s: `rptr[s]` (`ptr_width` bits) and `occ[s]` (`ptr_width+1` bits). `o_ptrs` and `o_occ` drive registered state directly.
- **Request rank.** For stream s and port p: rank(p,s) = number of ports q ≤ p with bit q*`nstrms`+s set.
- **Grant rule.** `i_req_r`[p*`nstrms`+s] = (rank(p,s) ≤ `occ[s]`).
  - Purely combinational from registered `occ` and `i_req_v`.
  - Ready for a bit that is not requested is don't-care.
  - This gives a prefix grant: if port p is refused for s, every higher port requesting s is also refused. This matches read ports computing their address as `rptr` plus the count of lower-numbered ports hitting the same stream.
- **Accepted count.** acc[s] = min(request count for s, `occ[s]`). Width is `$clog2(nports+1)`.
- **Write.** `i_wr_r` = (`occ[i_wr_sid]` != D). `o_wr_ptr` = (`rptr[i_wr_sid]` + `occ[i_wr_sid]`) mod D. A write fires when `i_wr_v` & `i_wr_r`.
- **Update per stream, each cycle:**
  - `rptr[s]` <= (`rptr[s]` + acc[s]) mod D. Wrap-around is natural truncation.
  - `occ[s]` <= `occ[s]` − acc[s] + (write fires and `i_wr_sid`==s).
- **Simultaneous events.**
  - A write in the same cycle is not visible to reads: the grant uses pre-write `occ`.
  - Read and write to the same stream in one cycle apply both deltas.
  - A full stream refuses writes even if reads drain it in that cycle. This avoids a ready→valid loop.
- **Flush.** When `i_flush_v`, stream `i_flush_sid` gets `occ` <= 0 and `rptr` <= `o_wr_ptr` for that stream, i.e. (`rptr` + `occ`) mod D.
  - Flush has priority: grants and writes to the flushed stream in that cycle are still signalled ready, but their state effect is discarded.
- **Occupancy bound.** `occ` never exceeds D or goes negative. An assertion must flag either condition.

## Timing
- **Reset.** All `rptr`=0 and `occ`=0 on the cycle after `reset` is high.
  - Therefore `o_ptrs`=0 and `o_occ`=0.
  - `i_req_r`=0 for every requested bit.
  - `i_wr_r`=1 and `o_wr_ptr`=0.
- **Reset mid-operation.** Discards all in-flight state; no grants are issued in the reset cycle.
- **Latency.** Grants and write ready are zero-latency (combinational). Pointer and occupancy updates are visible on `o_ptrs`/`o_occ` exactly 1 cycle after the handshake.
- **Throughput.** Up to `nports` grants per cycle in total, and up to `nports` to the same stream, plus one write per cycle.
- **No combinational path** from `i_wr_v` to `i_req_r`, or from `i_req_v` to `i_wr_r`.

## Test plan
- **Reset and empty.** `reset` 1 cycle; port 0 requests stream 3 → `i_req_r` low; `o_ptrs`=0, `o_occ`=0, `i_wr_r`=1.
- **Fill and read.** `ptr_width`=2: write stream 5 four times → `o_wr_ptr` 0,1,2,3; `occ[5]`=4, then `i_wr_r`=0. Ports 0,2,5 request stream 5 → all granted; next cycle `rptr[5]`=3, `occ[5]`=1.
- **Prefix grant.** `occ[7]`=2; ports 1,3,4,6 request stream 7 → ports 1 and 3 granted, 4 and 6 refused; `rptr[7]` +2.
- **Wrap.** `ptr_width`=2, `rptr[0]`=3, `occ`=3; 3 ports request → `rptr[0]`=2 next cycle, `occ`=0.
- **Simultaneous.** `occ[2]`=1; same cycle write stream 2 and 2 read requests → 1 granted; `occ[2]`=1 next cycle. `occ`=D with a read → write still refused.
- **Flush.** `rptr[4]`=1, `occ[4]`=2; flush 4 together with a granted read → next cycle `rptr[4]`=3, `occ[4]`=0. Random multi-stream traffic checked against a reference model.
